// File: rtl/v810_bus_resizer.sv
// V810 bus-side device adapter: emulates a 16/32-bit device with
// programmable wait states in front of a 32-bit synchronous RAM.
module v810_bus_resizer (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] WS,
  input  logic [31:0] DW,
  input  logic        CTLR_DAn,
  input  logic [3:0]  CTLR_BEn,
  output logic        CTLR_READYn,
  output logic        CTLR_SZRQn,
  output logic [31:0] CTLR_DI,
  input  logic [31:0] CTLR_DO,
  input  logic        MEM_nCE,
  output logic [31:0] MEM_DI,
  input  logic [31:0] MEM_DO
);

  logic       act;
  logic       wait_c;
  logic       split;
  logic [3:0] cnt;
  logic [3:0] lane_en;

  // Reset forces the shared outputs to their neutral values at once.
  assign act    = ~CTLR_DAn & ~MEM_nCE & ~RES;
  assign wait_c = ({28'd0, cnt} < WS);
  assign split  = (DW == 32'd16)
                & (CTLR_BEn[1:0] != 2'b11)
                & (CTLR_BEn[3:2] != 2'b11);

  always_ff @(posedge CLK) begin
    if (RES) begin
      cnt <= '0;
    end else if (CE) begin
      if (act && wait_c)
        cnt <= cnt + 4'd1;
      else
        cnt <= '0;
    end
  end

  assign CTLR_READYn = act & wait_c;
  assign CTLR_SZRQn  = ~(act & split);

  // A split access returns only the low halfword in its first cycle.
  assign lane_en = {4{act}} & ~CTLR_BEn
                 & {~split, ~split, 2'b11};

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign CTLR_DI[8*g +: 8] =
      lane_en[g] ? MEM_DO[8*g +: 8] : 8'hzz;
  end

  assign MEM_DI = CTLR_DO;

endmodule

// File: tb/tb_v810_bus_resizer.sv
// Scoreboard bench for v810_bus_resizer; a weak second driver
// on the read-data bus exposes lanes the adapter must leave floating.
module tb_v810_bus_resizer;

  logic        CLK = 1'b0;
  logic        RES;
  logic        CE;
  logic [31:0] WS;
  logic [31:0] DW;
  logic        CTLR_DAn;
  logic [3:0]  CTLR_BEn;
  logic        CTLR_READYn;
  logic        CTLR_SZRQn;
  wire  [31:0] di_bus;
  logic [31:0] CTLR_DO;
  logic        MEM_nCE;
  logic [31:0] MEM_DI;
  logic [31:0] MEM_DO;

  logic [3:0]  pull_en;
  logic [31:0] pull_val;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic        res;
    logic        ce;
    logic        dan;
    logic        nce;
    logic [3:0]  ben;
    logic [31:0] mdo;
    logic [31:0] cdo;
    logic        rdy;
    logic        sz;
    logic [3:0]  lanes;
  } row_t;

  typedef struct {
    string       nm;
    logic [65:0] v;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  v810_bus_resizer dut (
    .CLK         (CLK),
    .RES         (RES),
    .CE          (CE),
    .WS          (WS),
    .DW          (DW),
    .CTLR_DAn    (CTLR_DAn),
    .CTLR_BEn    (CTLR_BEn),
    .CTLR_READYn (CTLR_READYn),
    .CTLR_SZRQn  (CTLR_SZRQn),
    .CTLR_DI     (di_bus),
    .CTLR_DO     (CTLR_DO),
    .MEM_nCE     (MEM_nCE),
    .MEM_DI      (MEM_DI),
    .MEM_DO      (MEM_DO)
  );

  // Another bus agent drives the lanes this device should float.
  for (genvar g = 0; g < 4; g++) begin : g_pull
    assign di_bus[8*g +: 8] =
      pull_en[g] ? pull_val[8*g +: 8] : 8'hzz;
  end

  function automatic row_t mk(
    input string       nm,
    input logic        res,
    input logic        ce,
    input logic        dan,
    input logic        nce,
    input logic [3:0]  ben,
    input logic [31:0] mdo,
    input logic [31:0] cdo,
    input logic        rdy,
    input logic        sz,
    input logic [3:0]  lanes
  );
    row_t r;
    r.nm = nm; r.res = res; r.ce = ce;
    r.dan = dan; r.nce = nce; r.ben = ben;
    r.mdo = mdo; r.cdo = cdo;
    r.rdy = rdy; r.sz = sz; r.lanes = lanes;
    return r;
  endfunction

  task automatic step(input row_t r);
    exp_t        e;
    logic [31:0] d;
    @(negedge CLK);
    RES      = r.res;
    CE       = r.ce;
    CTLR_DAn = r.dan;
    MEM_nCE  = r.nce;
    CTLR_BEn = r.ben;
    MEM_DO   = r.mdo;
    CTLR_DO  = r.cdo;
    pull_en  = ~r.lanes;
    for (int i = 0; i < 4; i++)
      d[8*i +: 8] = r.lanes[i] ? r.mdo[8*i +: 8]
                               : pull_val[8*i +: 8];
    e.nm = r.nm;
    e.v  = {r.rdy, r.sz, d, r.cdo};
    sb.push_back(e);
  endtask

  task automatic test_reset();
    row_t        r[$];
    exp_t        e;
    logic [65:0] obs;
    WS = 32'd3;
    DW = 32'd16;
    r.push_back(mk("rst_a", 1, 1, 0, 0, 4'h0,
      32'h11223344, 32'h01020304, 0, 1, 4'h0));
    r.push_back(mk("rst_b", 1, 0, 0, 0, 4'h0,
      32'h55667788, 32'hA0B0C0D0, 0, 1, 4'h0));
    r.push_back(mk("rst_idle", 0, 1, 1, 0, 4'h0,
      32'h55667788, 32'h0, 0, 1, 4'h0));
    foreach (r[i]) begin
      step(r[i]);
      #1;
      e   = sb.pop_front();
      obs = {CTLR_READYn, CTLR_SZRQn, di_bus, MEM_DI};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s got %h exp %h", e.nm, obs, e.v);
      end
    end
  endtask

  task automatic test_zero_latency();
    row_t        r[$];
    exp_t        e;
    logic [65:0] obs;
    WS = 32'd0;
    DW = 32'd32;
    r.push_back(mk("zl_idle", 0, 1, 1, 0, 4'h0,
      32'h12345678, 32'h0, 0, 1, 4'h0));
    r.push_back(mk("zl_data", 0, 1, 0, 0, 4'h0,
      32'h12345678, 32'hDEADBEEF, 0, 1, 4'hF));
    r.push_back(mk("zl_be", 0, 1, 0, 0, 4'b1010,
      32'h87654321, 32'h13572468, 0, 1, 4'b0101));
    r.push_back(mk("zl_end", 0, 1, 1, 0, 4'h0,
      32'h12345678, 32'h0, 0, 1, 4'h0));
    foreach (r[i]) begin
      step(r[i]);
      #1;
      e   = sb.pop_front();
      obs = {CTLR_READYn, CTLR_SZRQn, di_bus, MEM_DI};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s got %h exp %h", e.nm, obs, e.v);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t        r[$];
    exp_t        e;
    logic [65:0] obs;
    logic        pat [6] = '{1, 1, 0, 1, 1, 0};
    WS = 32'd2;
    DW = 32'd32;
    for (int k = 0; k < 6; k++)
      r.push_back(mk("b2b", 0, 1, 0, 0, 4'h0,
        32'hC0DE0000 + k, 32'h100 + k, pat[k], 1, 4'hF));
    r.push_back(mk("b2b_end", 0, 1, 1, 0, 4'h0,
      32'h0, 32'h0, 0, 1, 4'h0));
    foreach (r[i]) begin
      step(r[i]);
      #1;
      e   = sb.pop_front();
      obs = {CTLR_READYn, CTLR_SZRQn, di_bus, MEM_DI};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s row %0d got %h exp %h",
          e.nm, i, obs, e.v);
      end
    end
  endtask

  task automatic test_split();
    row_t        r[$];
    exp_t        e;
    logic [65:0] obs;
    WS = 32'd0;
    DW = 32'd16;
    r.push_back(mk("sp_first", 0, 1, 0, 0, 4'h0,
      32'hAABBCCDD, 32'h0, 0, 0, 4'b0011));
    r.push_back(mk("sp_second", 0, 1, 0, 0, 4'b0011,
      32'hAABBCCDD, 32'h0, 0, 1, 4'b1100));
    r.push_back(mk("sp_mixed", 0, 1, 0, 0, 4'b0110,
      32'h01234567, 32'h0, 0, 0, 4'b0001));
    r.push_back(mk("sp_end", 0, 1, 1, 0, 4'h0,
      32'hAABBCCDD, 32'h0, 0, 1, 4'h0));
    foreach (r[i]) begin
      step(r[i]);
      #1;
      e   = sb.pop_front();
      obs = {CTLR_READYn, CTLR_SZRQn, di_bus, MEM_DI};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s got %h exp %h", e.nm, obs, e.v);
      end
    end
  endtask

  task automatic test_half_wait();
    row_t        r[$];
    exp_t        e;
    logic [65:0] obs;
    WS = 32'd1;
    DW = 32'd16;
    r.push_back(mk("hw_wait", 0, 1, 0, 0, 4'b1100,
      32'h99887766, 32'h0, 1, 1, 4'b0011));
    r.push_back(mk("hw_rdy", 0, 1, 0, 0, 4'b1100,
      32'h99887766, 32'h0, 0, 1, 4'b0011));
    r.push_back(mk("hw_end", 0, 1, 1, 0, 4'h0,
      32'h0, 32'h0, 0, 1, 4'h0));
    foreach (r[i]) begin
      step(r[i]);
      #1;
      e   = sb.pop_front();
      obs = {CTLR_READYn, CTLR_SZRQn, di_bus, MEM_DI};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s got %h exp %h", e.nm, obs, e.v);
      end
    end
    WS = 32'd0;
    DW = 32'd20;
    r.delete();
    r.push_back(mk("dw20", 0, 1, 0, 0, 4'h0,
      32'h24681357, 32'h0, 0, 1, 4'hF));
    r.push_back(mk("dw20_end", 0, 1, 1, 0, 4'h0,
      32'h0, 32'h0, 0, 1, 4'h0));
    foreach (r[i]) begin
      step(r[i]);
      #1;
      e   = sb.pop_front();
      obs = {CTLR_READYn, CTLR_SZRQn, di_bus, MEM_DI};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s got %h exp %h", e.nm, obs, e.v);
      end
    end
  endtask

  task automatic test_deselect();
    row_t        r[$];
    exp_t        e;
    logic [65:0] obs;
    WS = 32'd3;
    DW = 32'd16;
    for (int k = 0; k < 3; k++)
      r.push_back(mk("desel", 0, 1, 0, 1, 4'h0,
        32'h31415926, 32'hCAFEF00D, 0, 1, 4'h0));
    r.push_back(mk("desel_sel", 0, 1, 0, 0, 4'b1110,
      32'h31415926, 32'hCAFEF00D, 1, 1, 4'b0001));
    r.push_back(mk("desel_end", 0, 1, 1, 0, 4'h0,
      32'h0, 32'h0, 0, 1, 4'h0));
    foreach (r[i]) begin
      step(r[i]);
      #1;
      e   = sb.pop_front();
      obs = {CTLR_READYn, CTLR_SZRQn, di_bus, MEM_DI};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s got %h exp %h", e.nm, obs, e.v);
      end
    end
  endtask

  task automatic test_abort_and_ce();
    row_t        r[$];
    exp_t        e;
    logic [65:0] obs;
    WS = 32'd3;
    DW = 32'd32;
    r.push_back(mk("ab_w0", 0, 1, 0, 0, 4'h0,
      32'h0BADF00D, 32'h0, 1, 1, 4'hF));
    r.push_back(mk("ab_rst", 1, 1, 0, 0, 4'h0,
      32'h0BADF00D, 32'h0, 0, 1, 4'h0));
    for (int k = 0; k < 3; k++)
      r.push_back(mk("ab_wait", 0, 1, 0, 0, 4'h0,
        32'h0BADF00D, 32'h0, 1, 1, 4'hF));
    r.push_back(mk("ab_rdy", 0, 1, 0, 0, 4'h0,
      32'h0BADF00D, 32'h0, 0, 1, 4'hF));
    r.push_back(mk("ab_idle", 0, 1, 1, 0, 4'h0,
      32'h0, 32'h0, 0, 1, 4'h0));
    foreach (r[i]) begin
      step(r[i]);
      #1;
      e   = sb.pop_front();
      obs = {CTLR_READYn, CTLR_SZRQn, di_bus, MEM_DI};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s row %0d got %h exp %h",
          e.nm, i, obs, e.v);
      end
    end
    WS = 32'd2;
    r.delete();
    r.push_back(mk("ce_w0", 0, 1, 0, 0, 4'h0,
      32'h77777777, 32'h0, 1, 1, 4'hF));
    r.push_back(mk("ce_hold", 0, 0, 0, 0, 4'h0,
      32'h77777777, 32'h0, 1, 1, 4'hF));
    r.push_back(mk("ce_hold", 0, 0, 0, 0, 4'h0,
      32'h77777777, 32'h0, 1, 1, 4'hF));
    r.push_back(mk("ce_w1", 0, 1, 0, 0, 4'h0,
      32'h77777777, 32'h0, 1, 1, 4'hF));
    r.push_back(mk("ce_rdy", 0, 1, 0, 0, 4'h0,
      32'h77777777, 32'h0, 0, 1, 4'hF));
    r.push_back(mk("ce_next", 0, 1, 0, 0, 4'h0,
      32'h77777777, 32'h0, 1, 1, 4'hF));
    foreach (r[i]) begin
      step(r[i]);
      #1;
      e   = sb.pop_front();
      obs = {CTLR_READYn, CTLR_SZRQn, di_bus, MEM_DI};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s row %0d got %h exp %h",
          e.nm, i, obs, e.v);
      end
    end
  endtask

  initial begin
    RES      = 1'b1;
    CE       = 1'b1;
    WS       = 32'd0;
    DW       = 32'd32;
    CTLR_DAn = 1'b1;
    CTLR_BEn = 4'hF;
    CTLR_DO  = 32'h0;
    MEM_nCE  = 1'b1;
    MEM_DO   = 32'h0;
    pull_en  = 4'hF;
    pull_val = 32'h5A5A5A5A;
    test_reset();
    test_zero_latency();
    test_back_to_back();
    test_split();
    test_half_wait();
    test_deselect();
    test_abort_and_ce();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v810_bus_resizer.md
Name: v810_bus_resizer

Overview:
Bus-side memory device adapter used in V810 memory-controller benches. It sits between the controller's external bus (DAn, BEn, READYn, SZRQn, data) and a 32-bit synchronous RAM. It emulates a device of configurable data width (32 or 16 bit) with a configurable number of wait states. It inserts wait states by pulling READYn high. It requests bus sizing through SZRQn. It routes read and write data between controller and RAM.

Parameters:
none. Width and wait count are run-time inputs so a bench can change them between tests without re-elaborating.

Ports:
CLK  in  1  clock; all state updates on rising edge
RES  in  1  synchronous active-high reset
CE  in  1  clock enable; state advances only when CE=1
WS  in  32  wait states per data phase, legal 0..15
DW  in  32  emulated device width: 16 or 32; any other value behaves as 32
CTLR_DAn  in  1  controller data-phase strobe, active low
CTLR_BEn  in  4  byte enables, active low, lane i = bits [8i+7:8i]
CTLR_READYn  out  1  wired-OR ready; this block drives 1 to wait, 0 to be neutral
CTLR_SZRQn  out  1  wired-AND size request; this block drives 0 to request 16-bit sizing, 1 to be neutral
CTLR_DI  out  32  read data to controller, tristate per lane
CTLR_DO  in  32  write data from controller
MEM_nCE  in  1  device select, active low; when 1 the block is fully neutral
MEM_DI  out  32  write data to RAM
MEM_DO  in  32  read data from RAM (Z when RAM deselected)

Behaviour:
- Active condition: act = ~CTLR_DAn & ~MEM_nCE.
- Wait counter cnt, 4 bits.
  - Reset: cnt=0.
  - On an edge with CE=1: if act and cnt<WS, cnt increments.
  - Otherwise, if act and cnt==WS (ready cycle), cnt returns to 0.
  - If ~act, cnt returns to 0.
  - CE=0 holds cnt.
- Back-to-back data phases with DAn held low each receive a full WS waits.
- CTLR_READYn is combinational: 1 when act and cnt<WS, else 0. WS=0 gives ready in the first data-phase cycle (zero latency).
- Split condition: split = (DW==16) & (CTLR_BEn[1:0]!=2'b11) & (CTLR_BEn[3:2]!=2'b11), i.e. both halfwords enabled.
- CTLR_SZRQn is combinational: 0 when act and split, else 1.
  - It is held for the whole data phase, including wait cycles, so it is valid when READYn is sampled low.
  - The controller then issues a second cycle for the remaining half; that cycle has only one half enabled, so SZRQn stays 1.
- CTLR_DI:
  - When ~act, all 32 bits are Z.
  - When act, each lane equals the matching MEM_DO lane, bit for bit; Z on MEM_DO propagates.
  - Exception: when split, lanes 3:2 are driven Z, so only the lower halfword is returned in the first cycle.
  - Lanes whose BEn bit is 1 are driven Z.
- MEM_DI = CTLR_DO at all times. The RAM applies BEn itself. The block never masks write data.
- RES=1 gives cnt=0, READYn=0 and SZRQn=1 immediately (both outputs follow act, and act is forced neutral during reset), and CTLR_DI=Z.
- Reset mid-wait aborts the wait. The next data phase starts a fresh count.
- A WS or DW change while ~act takes effect at the next data phase. A change while act is illegal, and the result is unspecified but must not cause X on READYn.
- Multiple instances may share CTLR_DI, READYn and SZRQn. Neutral drive values (Z, 0, 1 respectively) guarantee no contention.

Test Plan:
1. DW=32, WS=0, BEn=0000, DAn low one cycle, MEM_DO=0x12345678 -> READYn=0 in the same cycle; CTLR_DI=0x12345678; SZRQn=1.
2. DW=32, WS=2, DAn held low -> READYn=1,1,0 over three cycles; with DAn held for six cycles the pattern repeats (1,1,0,1,1,0).
3. DW=16, WS=0, BEn=0000, MEM_DO=0xAABBCCDD -> SZRQn=0; CTLR_DI=0xZZZZCCDD. Second cycle with BEn=0011 -> SZRQn=1; CTLR_DI=0xAABBZZZZ.
4. DW=16, WS=1, BEn=1100 -> SZRQn=1 throughout; READYn=1 then 0; lanes 3:2 Z.
5. MEM_nCE=1 with DAn low, WS=3 -> READYn=0, SZRQn=1, CTLR_DI all Z; MEM_DI follows CTLR_DO (0xCAFEF00D).
6. RES asserted at cnt=1 of WS=3 -> next data phase after release shows READYn=1 for three full cycles; CE=0 during a wait extends it by the number of CE-low cycles.
